coin_sprite_stage: RTL and testbench

- Downstream consumer of the coin address detector.
- Takes its 19-bit coin ROM address and adds a spin-animation frame offset.
- Drives the synchronous coin ROM and registers the returned palette index into a pixel-aligned coin_on/coin_pal pair for the colour mapper.
- Tracks which of the three level coins the player has collected, using a once-per-video-frame check FSM.

---
 rtl/coin_sprite_stage_if.sv | 38 +++
 rtl/coin_sprite_stage.sv | 216 +++++++++++++++++++++
 tb/tb_coin_sprite_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/coin_sprite_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : coin_sprite_stage_if
//  Description : Pixel, player, ROM and status signals of the coin sprite
//                stage. The master side is the video/game environment and
//                coin ROM; the slave side is the sprite stage itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface coin_sprite_stage_if;
    logic        frame_clk;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [5:0]  logx;
    logic [18:0] read_addr;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic        clear_coins;
    logic [18:0] rom_addr;
    logic [3:0]  rom_data;
    logic        coin_on;
    logic [3:0]  coin_pal;
    logic [2:0]  collected;
    logic [7:0]  coin_count;
    logic        collect_pulse;

    modport master (
        output frame_clk, DrawX, DrawY, logx, read_addr, player_x, player_y,
               clear_coins, rom_data,
        input  rom_addr, coin_on, coin_pal, collected, coin_count, collect_pulse
    );

    modport slave (
        input  frame_clk, DrawX, DrawY, logx, read_addr, player_x, player_y,
               clear_coins, rom_data,
        output rom_addr, coin_on, coin_pal, collected, coin_count, collect_pulse
    );
endinterface
`default_nettype wire

// File: rtl/coin_sprite_stage.sv
`default_nettype none
// ============================================================================
//  Module      : coin_sprite_stage
//  Description : Adds the spin-animation frame offset to the coin ROM address,
//                aligns the returned palette index with the pixel (latency 3),
//                and tracks which of the three level coins were collected.
//  Revision    : 1.0  initial release
// ============================================================================
module coin_sprite_stage #(
    parameter int ANIM_DIV    = 8,
    parameter int FRAME_WORDS = 300,
    parameter int PLAYER_W    = 16,
    parameter int PLAYER_H    = 16
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    coin_sprite_stage_if.slave    bus
);

    localparam int c_DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    // Coin boxes in world coordinates; bounds are exclusive on every side.
    localparam logic [2:0][10:0] c_XLO = {11'd260, 11'd230, 11'd140};
    localparam logic [2:0][10:0] c_XHI = {11'd275, 11'd245, 11'd155};
    localparam logic [2:0][10:0] c_YLO = {11'd278, 11'd278, 11'd378};
    localparam logic [2:0][10:0] c_YHI = {11'd298, 11'd298, 11'd398};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHK  = 2'd1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_idx, w_idx_nxt;
    logic               w_collect;
    logic [2:0]         w_idx_oh;

    logic [1:0]         r_fsync;
    logic               r_fsync_d;
    logic               w_tick;
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_frame;

    logic [10:0]        w_wx, w_wy;
    logic [2:0]         w_hit, r_hit_d1, r_hit_d2;
    logic [18:0]        r_rom_addr;
    logic               w_on, r_coin_on;
    logic [3:0]         r_coin_pal;

    logic [2:0]         r_collected;
    logic [7:0]         r_count;
    logic               r_pulse;

    logic [11:0]        w_plx, w_prx, w_pty, w_pby;
    logic [11:0]        w_sxlo, w_sxhi, w_sylo, w_syhi;
    logic               w_overlap;

    // Pixel position in world space; scroll is horizontal only.
    assign w_wx = {1'b0, bus.DrawX} + {5'b0, bus.logx};
    assign w_wy = {1'b0, bus.DrawY};

    for (genvar gi = 0; gi < 3; gi++) begin : g_coin
        assign w_hit[gi] = (w_wx > c_XLO[gi]) && (w_wx < c_XHI[gi]) &&
                           (w_wy > c_YLO[gi]) && (w_wy < c_YHI[gi]) &&
                           !r_collected[gi];
    end

    // Frame-clock synchroniser and rising-edge detect.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fsync   <= 2'b00;
            r_fsync_d <= 1'b0;
        end else begin
            r_fsync   <= {r_fsync[0], bus.frame_clk};
            r_fsync_d <= r_fsync[1];
        end
    end

    assign w_tick = r_fsync[1] & ~r_fsync_d;

    // Animation: advance the spin frame every ANIM_DIV video frames.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div   <= '0;
            r_frame <= 2'd0;
        end else if (w_tick) begin
            if (r_div == c_DIV_W'(ANIM_DIV - 1)) begin
                r_div   <= '0;
                r_frame <= r_frame + 2'd1;
            end else begin
                r_div <= r_div + c_DIV_W'(1);
            end
        end
    end

    // Three-stage pixel pipeline: address, ROM read, visibility decision.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr <= '0;
            r_hit_d1   <= 3'b000;
            r_hit_d2   <= 3'b000;
            r_coin_on  <= 1'b0;
            r_coin_pal <= 4'd0;
        end else begin
            r_rom_addr <= bus.read_addr + 19'(r_frame) * 19'(FRAME_WORDS);
            r_hit_d1   <= w_hit;
            r_hit_d2   <= r_hit_d1;
            r_coin_on  <= w_on;
            r_coin_pal <= w_on ? bus.rom_data : 4'd0;
        end
    end

    // Palette index 0 is transparent.
    assign w_on = (|r_hit_d2) && (bus.rom_data != 4'd0);

    // Player box, widened to 12 bits so the right/bottom edges never wrap.
    assign w_plx = {2'b00, bus.player_x} + {6'b0, bus.logx};
    assign w_prx = w_plx + 12'(PLAYER_W);
    assign w_pty = {2'b00, bus.player_y};
    assign w_pby = w_pty + 12'(PLAYER_H);

    // Select the box of the coin under test and its one-hot mask.
    always_comb begin
        w_sxlo   = {1'b0, c_XLO[2]};
        w_sxhi   = {1'b0, c_XHI[2]};
        w_sylo   = {1'b0, c_YLO[2]};
        w_syhi   = {1'b0, c_YHI[2]};
        w_idx_oh = 3'b100;
        case (r_idx)
            2'd0: begin
                w_sxlo = {1'b0, c_XLO[0]}; w_sxhi = {1'b0, c_XHI[0]};
                w_sylo = {1'b0, c_YLO[0]}; w_syhi = {1'b0, c_YHI[0]};
                w_idx_oh = 3'b001;
            end
            2'd1: begin
                w_sxlo = {1'b0, c_XLO[1]}; w_sxhi = {1'b0, c_XHI[1]};
                w_sylo = {1'b0, c_YLO[1]}; w_syhi = {1'b0, c_YHI[1]};
                w_idx_oh = 3'b010;
            end
            default: ;
        endcase
    end

    // Interior pixels of a box are lo+1..hi-1; the player box is half-open.
    assign w_overlap = (w_plx < w_sxhi) && (w_prx > w_sxlo + 12'd1) &&
                       (w_pty < w_syhi) && (w_pby > w_sylo + 12'd1) &&
                       ((r_collected & w_idx_oh) == 3'b000);

    // Collection FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Collection FSM next state: one coin per CHK cycle; clear overrides all.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_collect   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = ST_CHK;
                    w_idx_nxt   = 2'd0;
                end
            end
            ST_CHK: begin
                w_collect = w_overlap;
                if (r_idx == 2'd2) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idx_nxt = r_idx + 2'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.clear_coins) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 2'd0;
            w_collect   = 1'b0;
        end
    end

    // Collected flags, saturating coin counter and the per-collect pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_collected <= 3'b000;
            r_count     <= 8'd0;
            r_pulse     <= 1'b0;
        end else begin
            r_pulse <= w_collect;
            if (bus.clear_coins) begin
                r_collected <= 3'b000;
            end else if (w_collect) begin
                r_collected <= r_collected | w_idx_oh;
                if (r_count != 8'd255) begin
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end

    assign bus.rom_addr      = r_rom_addr;
    assign bus.coin_on       = r_coin_on;
    assign bus.coin_pal      = r_coin_pal;
    assign bus.collected     = r_collected;
    assign bus.coin_count    = r_count;
    assign bus.collect_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_coin_sprite_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_sprite_stage
//  Description : Scoreboard bench for coin_sprite_stage. Stimulus pushes the
//                expected ROM address, pixel output and collect events into
//                queues; monitors pop and compare when the DUT presents them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_coin_sprite_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    coin_sprite_stage_if ifa ();
    coin_sprite_stage_if ifb ();

    coin_sprite_stage u_dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (ifa)
    );

    coin_sprite_stage #(.PLAYER_W(30)) u_dut30 (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (ifb)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [18:0] addr_q[$];
    logic [4:0]  pix_q[$];
    logic [10:0] pulse_a_q[$];
    logic [10:0] pulse_b_q[$];
    int          b_cycles[$];

    logic        probe     = 1'b0;
    logic [2:0]  mark      = 3'b000;
    logic [3:0]  rom_val   = 4'd0;
    logic [18:0] rom_match = 19'd0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Synchronous coin ROM model: returns rom_val only at the expected address.
    always @(posedge clk) begin
        ifa.rom_data <= (ifa.rom_addr == rom_match) ? rom_val : 4'd0;
        ifb.rom_data <= 4'd0;
        mark         <= {mark[1:0], probe};
        cyc          <= cyc + 1;
    end

    // Pixel monitor: address one cycle after the probe, pixel three after.
    always @(negedge clk) begin
        if (mark[0]) begin
            if (addr_q.size() == 0) check("addr_q_underflow", 1, 0);
            else check("rom_addr", int'(ifa.rom_addr), int'(addr_q.pop_front()));
        end
        if (mark[2]) begin
            if (pix_q.size() == 0) check("pix_q_underflow", 1, 0);
            else check("coin_on_pal", int'({ifa.coin_on, ifa.coin_pal}),
                       int'(pix_q.pop_front()));
        end
    end

    // Collect monitors: every pulse must match a queued {collected, count}.
    always @(negedge clk) begin
        if (rst_n && ifa.collect_pulse) begin
            if (pulse_a_q.size() == 0) check("a_unexpected_pulse", 1, 0);
            else check("a_collect", int'({ifa.collected, ifa.coin_count}),
                       int'(pulse_a_q.pop_front()));
        end
        if (rst_n && ifb.collect_pulse) begin
            b_cycles.push_back(cyc);
            if (pulse_b_q.size() == 0) check("b_unexpected_pulse", 1, 0);
            else check("b_collect", int'({ifb.collected, ifb.coin_count}),
                       int'(pulse_b_q.pop_front()));
        end
    end

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [5:0] lx,
                       input logic [18:0] ra, input logic [3:0] rv,
                       input logic [18:0] exp_addr, input logic exp_on,
                       input logic [3:0] exp_pal);
        ifa.DrawX     = x;
        ifa.DrawY     = y;
        ifa.logx      = lx;
        ifa.read_addr = ra;
        rom_val       = rv;
        rom_match     = exp_addr;
        addr_q.push_back(exp_addr);
        pix_q.push_back({exp_on, exp_pal});
        probe = 1'b1;
        @(negedge clk);
        probe         = 1'b0;
        ifa.DrawX     = 10'd0;
        ifa.DrawY     = 10'd0;
        ifa.logx      = 6'd0;
        ifa.read_addr = 19'd0;
        repeat (4) @(negedge clk);
    endtask

    task automatic edge_a(input int n);
        for (int i = 0; i < n; i++) begin
            ifa.frame_clk = 1'b1;
            repeat (4) @(negedge clk);
            ifa.frame_clk = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic pulse_clear_a();
        ifa.clear_coins = 1'b1;
        @(negedge clk);
        ifa.clear_coins = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        ifa.frame_clk = 0; ifa.DrawX = 0; ifa.DrawY = 0; ifa.logx = 0;
        ifa.read_addr = 0; ifa.player_x = 0; ifa.player_y = 0; ifa.clear_coins = 0;
        ifb.frame_clk = 0; ifb.DrawX = 0; ifb.DrawY = 0; ifb.logx = 0;
        ifb.read_addr = 0; ifb.player_x = 0; ifb.player_y = 0; ifb.clear_coins = 0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_rom_addr", int'(ifa.rom_addr), 0);
        check("rst_coin_on", int'(ifa.coin_on), 0);
        check("rst_coin_pal", int'(ifa.coin_pal), 0);
        check("rst_collected", int'(ifa.collected), 0);
        check("rst_coin_count", int'(ifa.coin_count), 0);
        check("rst_pulse", int'(ifa.collect_pulse), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pixel pipeline and box boundaries (frame 0).
        pix(10'd145, 10'd380, 6'd0, 19'd77, 4'd5, 19'd77, 1'b1, 4'd5);
        pix(10'd145, 10'd380, 6'd0, 19'd77, 4'd0, 19'd77, 1'b0, 4'd0);
        pix(10'd140, 10'd380, 6'd0, 19'd77, 4'd5, 19'd77, 1'b0, 4'd0);
        pix(10'd141, 10'd380, 6'd0, 19'd78, 4'd9, 19'd78, 1'b1, 4'd9);
        pix(10'd155, 10'd380, 6'd0, 19'd77, 4'd5, 19'd77, 1'b0, 4'd0);
        pix(10'd154, 10'd397, 6'd0, 19'd80, 4'd2, 19'd80, 1'b1, 4'd2);
        pix(10'd154, 10'd398, 6'd0, 19'd80, 4'd2, 19'd80, 1'b0, 4'd0);
        pix(10'd100, 10'd380, 6'd45, 19'd81, 4'd6, 19'd81, 1'b1, 4'd6);
        pix(10'd240, 10'd290, 6'd0, 19'd10, 4'd3, 19'd10, 1'b1, 4'd3);
        pix(10'd270, 10'd290, 6'd0, 19'd11, 4'd7, 19'd11, 1'b1, 4'd7);

        // Animation: 8 frames -> frame 1, 32 frames -> back to frame 0.
        edge_a(8);
        pix(10'd145, 10'd380, 6'd0, 19'd77, 4'd5, 19'd377, 1'b1, 4'd5);
        edge_a(24);
        pix(10'd145, 10'd380, 6'd0, 19'd77, 4'd5, 19'd77, 1'b1, 4'd5);

        // Collect coin1; it then disappears and stays collected.
        ifa.player_x = 10'd232;
        ifa.player_y = 10'd280;
        pulse_a_q.push_back({3'b010, 8'd1});
        edge_a(1);
        pix(10'd235, 10'd285, 6'd0, 19'd77, 4'd5, 19'd77, 1'b0, 4'd0);
        edge_a(2);
        check("a_collected_hold", int'(ifa.collected), 2);
        check("a_count_hold", int'(ifa.coin_count), 1);

        // Wide player overlapping coin1 and coin2 on the second instance.
        ifb.player_x = 10'd240;
        ifb.player_y = 10'd285;
        pulse_b_q.push_back({3'b010, 8'd1});
        pulse_b_q.push_back({3'b110, 8'd2});
        ifb.frame_clk = 1'b1;
        repeat (4) @(negedge clk);
        ifb.frame_clk = 1'b0;
        repeat (6) @(negedge clk);
        check("b_collected", int'(ifb.collected), 6);
        check("b_count", int'(ifb.coin_count), 2);
        check("b_pulse_n", b_cycles.size(), 2);
        if (b_cycles.size() == 2) check("b_pulse_gap", b_cycles[1] - b_cycles[0], 1);

        // Clear in the same cycle coin0 would be collected: clear wins.
        ifa.player_x = 10'd142;
        ifa.player_y = 10'd380;
        ifa.frame_clk = 1'b1;
        repeat (3) @(negedge clk);
        ifa.clear_coins = 1'b1;
        @(negedge clk);
        ifa.clear_coins = 1'b0;
        repeat (3) @(negedge clk);
        ifa.frame_clk = 1'b0;
        repeat (4) @(negedge clk);
        check("clr_collected", int'(ifa.collected), 0);
        check("clr_count", int'(ifa.coin_count), 1);

        // Repeated collect/clear drives the counter into saturation.
        for (int k = 2; k <= 258; k++) begin
            exp_cnt = (k > 255) ? 255 : k;
            pulse_a_q.push_back({3'b001, 8'(exp_cnt)});
            edge_a(1);
            pulse_clear_a();
        end
        check("sat_count", int'(ifa.coin_count), 255);
        check("sat_collected", int'(ifa.collected), 0);

        repeat (5) @(negedge clk);
        check("a_pulse_drain", pulse_a_q.size(), 0);
        check("b_pulse_drain", pulse_b_q.size(), 0);
        check("addr_drain", addr_q.size(), 0);
        check("pix_drain", pix_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
